// File: rtl/pipe_calc.sv
// ---------------------------------------------------------------------------
// pipe_calc -- single-stage signed add/subtract/abs unit with an accumulator.
//
// A request (op, acc_sel, a, b) is accepted when in_valid && in_ready. The
// result is registered into a one-entry output stage one cycle later. The
// same result, after wrap or saturation, is also written into the
// accumulator. When acc_sel=1, the accumulator replaces operand A, so
// back-to-back accumulation runs at full rate.
//
// Parameters
//   W    operand/result width (signed two's complement, 4..64)
//   SAT  0 = wrap on overflow, 1 = saturate on overflow
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   in_valid/ready  request handshake (in_ready = !out_valid || out_ready)
//   op[2:0]         000 A+B, 001 A-B, 01x abs(B), 100 B+A, 101 B-A, 11x abs(A)
//   acc_sel         1 = use accumulator as operand A
//   a, b            signed operands
//   out_valid/ready result handshake
//   r, ovf          result and its overflow flag
//   ovf_sticky      OR of ovf over accepted requests since reset/clear
//   clr             synchronous clear of acc and ovf_sticky (wins over update)
//   acc             current accumulator value
// ---------------------------------------------------------------------------
module pipe_calc #(
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2:0]          op,
    input  logic                acc_sel,
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic signed [W-1:0] r,
    output logic                ovf,
    output logic                ovf_sticky,
    input  logic                clr,
    output logic signed [W-1:0] acc
);

    localparam logic [W-1:0] C_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] C_MIN = {1'b1, {(W-1){1'b0}}};

    logic         r_out_valid;
    logic [W-1:0] r_r;
    logic         r_ovf;
    logic         r_ovf_sticky;
    logic [W-1:0] r_acc;

    logic         w_accept;
    logic [W-1:0] w_opa;
    logic [W-1:0] w_x;
    logic [W-1:0] w_y;
    logic [W-1:0] w_sum;
    logic [W-1:0] w_diff;
    logic [W-1:0] w_abs_in;
    logic [W-1:0] w_res_raw;
    logic [W-1:0] w_sat_val;
    logic         w_ovf;
    logic [W-1:0] w_res;

    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

    // op[2] swaps the operand order for add/subtract and picks A vs B for abs.
    assign w_opa    = acc_sel ? r_acc : a;
    assign w_x      = op[2] ? b : w_opa;
    assign w_y      = op[2] ? w_opa : b;
    assign w_sum    = w_x + w_y;
    assign w_diff   = w_x - w_y;
    assign w_abs_in = op[2] ? w_opa : b;

    always_comb begin
        w_res_raw = w_sum;
        w_ovf     = 1'b0;
        w_sat_val = C_MAX;
        if (op[1]) begin
            // abs: the only unrepresentable case is the most negative value,
            // whose negation wraps back onto itself.
            w_res_raw = w_abs_in[W-1] ? ({W{1'b0}} - w_abs_in) : w_abs_in;
            w_ovf     = (w_abs_in == C_MIN);
            w_sat_val = C_MAX;
        end else if (op[0]) begin
            w_res_raw = w_diff;
            w_ovf     = (w_x[W-1] != w_y[W-1]) && (w_diff[W-1] != w_x[W-1]);
            // Overflow direction follows the minuend's sign.
            w_sat_val = w_x[W-1] ? C_MIN : C_MAX;
        end else begin
            w_res_raw = w_sum;
            w_ovf     = (w_x[W-1] == w_y[W-1]) && (w_sum[W-1] != w_x[W-1]);
            w_sat_val = w_x[W-1] ? C_MIN : C_MAX;
        end
    end

    assign w_res = ((SAT != 0) && w_ovf) ? w_sat_val : w_res_raw;

    // Output stage: loads on accept, drains when the consumer takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_r         <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_r         <= w_res;
                r_ovf       <= w_ovf;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Accumulator and sticky flag; clr takes priority over an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (clr) begin
            r_acc        <= '0;
            r_ovf_sticky <= 1'b0;
        end else if (w_accept) begin
            r_acc <= w_res;
            if (w_ovf) begin
                r_ovf_sticky <= 1'b1;
            end
        end
    end

    assign out_valid  = r_out_valid;
    assign r          = r_r;
    assign ovf        = r_ovf;
    assign ovf_sticky = r_ovf_sticky;
    assign acc        = r_acc;

endmodule

// File: tb/tb_pipe_calc.sv
// ---------------------------------------------------------------------------
// tb_pipe_calc -- scoreboard bench for pipe_calc. Two instances (wrap and
// saturate) share one stimulus stream; the driver pushes hand-computed
// expected results into per-instance queues and a negedge monitor pops and
// compares whenever a result is handed over (out_valid && out_ready).
// ---------------------------------------------------------------------------
module tb_pipe_calc;

    typedef struct {
        logic signed [15:0] r;
        logic               ovf;
    } exp_t;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic [2:0]         op;
    logic               acc_sel;
    logic signed [15:0] a;
    logic signed [15:0] b;
    logic               out_ready;
    logic               clr;

    logic               ir0, ov0, ovf0, st0;
    logic signed [15:0] r0, acc0;
    logic               ir1, ov1, ovf1, st1;
    logic signed [15:0] r1, acc1;

    exp_t q0[$];
    exp_t q1[$];
    exp_t m0, m1;
    logic st_exp;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_calc #(.W(16), .SAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir0),
        .op(op), .acc_sel(acc_sel), .a(a), .b(b),
        .out_valid(ov0), .out_ready(out_ready), .r(r0), .ovf(ovf0),
        .ovf_sticky(st0), .clr(clr), .acc(acc0)
    );

    pipe_calc #(.W(16), .SAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir1),
        .op(op), .acc_sel(acc_sel), .a(a), .b(b),
        .out_valid(ov1), .out_ready(out_ready), .r(r1), .ovf(ovf1),
        .ovf_sticky(st1), .clr(clr), .acc(acc1)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: compares every handed-over result against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out0: got r=%0d with empty queue", r0);
            end else begin
                m0 = q0.pop_front();
                $display("dut0 out r=%0d ovf=%0b (exp %0d/%0b)", r0, ovf0, m0.r, m0.ovf);
                chk("r0", r0, m0.r);
                chk("ovf0", ovf0, m0.ovf);
            end
        end
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_out1: got r=%0d with empty queue", r1);
            end else begin
                m1 = q1.pop_front();
                $display("dut1 out r=%0d ovf=%0b (exp %0d/%0b)", r1, ovf1, m1.r, m1.ovf);
                chk("r1", r1, m1.r);
                chk("ovf1", ovf1, m1.ovf);
            end
        end
    end

    // Issue one request (called at posedge+1); checks acc/sticky after accept.
    task automatic issue(input logic [2:0] o, input logic s, input logic c,
                         input logic signed [15:0] av, input logic signed [15:0] bv,
                         input logic signed [15:0] e0, input logic f0,
                         input logic signed [15:0] e1, input logic f1);
        int  n;
        bit  accepted;
        op = o; acc_sel = s; a = av; b = bv; clr = c; in_valid = 1'b1;
        q0.push_back('{e0, f0});
        q1.push_back('{e1, f1});
        n = 0; accepted = 0;
        while (!accepted && n < 20) begin
            @(negedge clk);
            if (ir0) accepted = 1;
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        clr = 1'b0;
        if (!accepted) begin
            checks++; errors++;
            $display("FAIL accept_timeout: got no accept in %0d cycles, required accept", n);
        end
        st_exp = c ? 1'b0 : (st_exp | f0);
        chk("acc0", acc0, c ? 16'sd0 : e0);
        chk("acc1", acc1, c ? 16'sd0 : e1);
        chk("sticky0", st0, st_exp);
        chk("sticky1", st1, st_exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; acc_sel = 1'b0;
        a = '0; b = '0; out_ready = 1'b1; clr = 1'b0; st_exp = 1'b0;
        #1;
        chk("rst_ov0", ov0, 1'b0);
        chk("rst_r0", r0, 16'sd0);
        chk("rst_acc0", acc0, 16'sd0);
        chk("rst_st0", st0, 1'b0);
        chk("rst_ir0", ir0, 1'b1);
        chk("rst_ir1", ir1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors: op, acc_sel, clr, a, b, wrap result, saturate result
        issue(3'b000, 0, 0, 16'sd10, 16'sd5, 16'sd15, 0, 16'sd15, 0);
        issue(3'b000, 0, 0, 16'sd32760, 16'sd100, -16'sd32676, 1, 16'sd32767, 1);
        issue(3'b001, 0, 0, -16'sd32760, 16'sd100, 16'sd32676, 1, 16'sh8000, 1);
        issue(3'b110, 0, 0, 16'sh8000, 16'sd0, 16'sh8000, 1, 16'sd32767, 1);
        issue(3'b010, 0, 0, 16'sd0, -16'sd100, 16'sd100, 0, 16'sd100, 0);
        issue(3'b100, 0, 0, 16'sd3, -16'sd10, -16'sd7, 0, -16'sd7, 0);
        issue(3'b101, 0, 0, 16'sd3, -16'sd10, -16'sd13, 0, -16'sd13, 0);
        issue(3'b101, 0, 0, 16'sd100, -16'sd32760, 16'sd32676, 1, 16'sh8000, 1);
        issue(3'b011, 0, 0, 16'sd9, 16'sh8000, 16'sh8000, 1, 16'sd32767, 1);
        issue(3'b111, 0, 0, -16'sd5, 16'sd9, 16'sd5, 0, 16'sd5, 0);
        issue(3'b000, 0, 0, -16'sd32000, -16'sd1000, 16'sd32536, 1, 16'sh8000, 1);
        issue(3'b001, 0, 0, 16'sd0, 16'sh8000, 16'sh8000, 1, 16'sd32767, 1);

        // Stand-alone clear
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        st_exp = 1'b0;
        chk("clr_acc0", acc0, 16'sd0);
        chk("clr_acc1", acc1, 16'sd0);
        chk("clr_st0", st0, 1'b0);
        chk("clr_st1", st1, 1'b0);

        // Back-to-back accumulation; operand a is junk and must be ignored
        issue(3'b000, 1, 0, 16'sd1000, 16'sd7, 16'sd7, 0, 16'sd7, 0);
        issue(3'b000, 1, 0, 16'sd1000, 16'sd7, 16'sd14, 0, 16'sd14, 0);
        issue(3'b000, 1, 0, 16'sd1000, 16'sd7, 16'sd21, 0, 16'sd21, 0);
        // Accumulator feedback with clr on the same edge: result normal, acc cleared
        issue(3'b000, 1, 1, 16'sd0, 16'sd5, 16'sd26, 0, 16'sd26, 0);
        // Overflowing request with clr: sticky must stay clear
        issue(3'b000, 0, 1, 16'sd32760, 16'sd100, -16'sd32676, 1, 16'sd32767, 1);

        // Backpressure: drain first, then stall a result
        @(posedge clk); #1;
        out_ready = 1'b0;
        issue(3'b000, 0, 0, 16'sd1, 16'sd2, 16'sd3, 0, 16'sd3, 0);
        op = 3'b000; acc_sel = 1'b0; a = 16'sd100; b = 16'sd200; in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready0", ir0, 1'b0);
            chk("bp_valid0", ov0, 1'b1);
            chk("bp_r0", r0, 16'sd3);
            chk("bp_acc0", acc0, 16'sd3);
            @(posedge clk); #1;
        end
        q0.push_back('{16'sd300, 1'b0});
        q1.push_back('{16'sd300, 1'b0});
        out_ready = 1'b1;
        @(negedge clk);
        chk("drain_ready0", ir0, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("drain_r0", r0, 16'sd300);
        chk("drain_valid0", ov0, 1'b1);
        @(posedge clk); #1;
        chk("fall_valid0", ov0, 1'b0);
        chk("fall_valid1", ov1, 1'b0);

        // Reset with a pending result
        out_ready = 1'b0;
        issue(3'b000, 0, 0, 16'sd4, 16'sd4, 16'sd8, 0, 16'sd8, 0);
        #2;
        rst_n = 1'b0;
        #1;
        q0.delete();
        q1.delete();
        st_exp = 1'b0;
        chk("arst_valid0", ov0, 1'b0);
        chk("arst_valid1", ov1, 1'b0);
        chk("arst_r0", r0, 16'sd0);
        chk("arst_acc0", acc0, 16'sd0);
        chk("arst_ready0", ir0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        op = 3'b000; acc_sel = 1'b0; a = 16'sd1; b = 16'sd1; in_valid = 1'b1;
        q0.push_back('{16'sd2, 1'b0});
        q1.push_back('{16'sd2, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("first_edge_valid0", ov0, 1'b1);
        chk("first_edge_acc0", acc0, 16'sd2);

        repeat (3) @(posedge clk);
        #1;
        chk("q0_empty", q0.size(), 0);
        chk("q1_empty", q1.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipe_calc.md
PIPE_CALC -- requirements
Module: pipe_calc

Interface
REQ-001 The block SHALL provide parameter W, default 16: the signed two's-complement operand and result width, legal range 4..64.
REQ-002 The block SHALL provide parameter SAT, default 0: 0 wraps results on overflow, 1 saturates them.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 Port in_valid, input, 1 bit: op, acc_sel, a and b hold a request.
REQ-006 Port in_ready, output, 1 bit: the block can accept a request this cycle.
REQ-007 Port op, input, 3 bits: 000 A+B; 001 A-B; 010/011 abs(B); 100 B+A; 101 B-A; 110/111 abs(A).
REQ-008 Port acc_sel, input, 1 bit: 1 substitutes the accumulator register for operand A.
REQ-009 Port a, input, W bits, signed: operand A.
REQ-010 Port b, input, W bits, signed: operand B.
REQ-011 Port out_valid, output, 1 bit: r and ovf hold a result.
REQ-012 Port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-013 Port r, output, W bits, signed: the result.
REQ-014 Port ovf, output, 1 bit: the result in r overflowed.
REQ-015 Port ovf_sticky, output, 1 bit: OR of ovf over all accepted requests since the last reset or clear.
REQ-016 Port clr, input, 1 bit: synchronous clear of the accumulator and ovf_sticky.
REQ-017 Port acc, output, W bits, signed: the current accumulator value.

Function
REQ-018 A request SHALL be accepted on a rising edge where in_valid=1 and in_ready=1.
REQ-019 in_ready SHALL equal (!out_valid || out_ready), combinationally; the output holds one entry with full throughput and no bubble.
REQ-020 An accepted request SHALL load r and ovf and set out_valid=1 on the same edge; latency is 1 cycle.
REQ-021 out_valid SHALL fall on an edge where out_ready=1 and no request is accepted.
REQ-022 r, ovf and out_valid SHALL hold stable while out_valid=1 and out_ready=0.
REQ-023 The effective A operand SHALL be acc when acc_sel=1, and a otherwise.
REQ-024 Add overflow SHALL be flagged when both operands have the same sign and the W-bit sum has the opposite sign.
REQ-025 Subtract overflow SHALL be flagged when the operand signs differ and the W-bit result sign differs from the minuend sign.
REQ-026 abs overflow SHALL be flagged only when the operand equals -2^(W-1).
REQ-027 With SAT=0, an overflowing result SHALL be the W-bit wrapped value; abs(-2^(W-1)) returns -2^(W-1).
REQ-028 With SAT=1, an overflowing result SHALL clamp to +2^(W-1)-1 on positive overflow and -2^(W-1) on negative overflow; abs overflow clamps to +2^(W-1)-1.
REQ-029 Each accepted request SHALL write its final result (after wrap or saturation) into acc on the accept edge.
REQ-030 Each accepted request with overflow SHALL set ovf_sticky on the accept edge.
REQ-031 When clr=1, acc and ovf_sticky SHALL become 0 on that edge.
REQ-032 When clr=1 coincides with an accepted request, clr SHALL win for acc and ovf_sticky, and r/ovf SHALL still be produced normally.
REQ-033 Accumulator feedback back-to-back SHALL use the acc value written by the previous accepted request, with no stall.
REQ-034 Operands are sampled only at accept; input changes at any other time SHALL have no effect.

Reset
REQ-035 While rst_n=0, out_valid, r, ovf, acc and ovf_sticky SHALL all be 0, asynchronously.
REQ-036 While rst_n=0, in_ready SHALL be 1.
REQ-037 Reset asserted mid-transaction SHALL discard the pending result.
REQ-038 The first edge after rst_n rises SHALL be able to accept a request.

Verification
REQ-039 W=16, SAT=0: op=000, a=10, b=5, out_ready=1 -> next cycle r=15, ovf=0, acc=15.
REQ-040 op=000, a=32760, b=100 -> SAT=0: r=-32676, ovf=1, ovf_sticky=1; SAT=1: r=32767, ovf=1.
REQ-041 op=001, a=-32760, b=100 -> SAT=0: r=32676, ovf=1; SAT=1: r=-32768, ovf=1.
REQ-042 op=110, a=-32768 -> SAT=0: r=-32768, ovf=1; SAT=1: r=32767, ovf=1. op=010, b=-100 -> r=100, ovf=0.
REQ-043 Accumulate: clr, then three back-to-back requests op=000, acc_sel=1, b=7 -> r=7, 14, 21 on consecutive cycles.
REQ-044 Backpressure: hold out_ready=0 with a result pending -> in_ready=0, r held. Then assert out_ready=1 with in_valid=1 -> result drained and new request accepted on the same edge. Then assert rst_n=0 with out_valid=1 -> out_valid=0 immediately.
